// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame defaults, receiver state encoding and the
// even-parity convention used by the receiver, transmitter and ALU interface.
package uart_rx_pkg;

    localparam int DEF_N_DATA       = 8;
    localparam int DEF_PARITY_CHECK = 1;
    localparam int DEF_N_TICKS      = 16;

    // Widest data word the parity helper accepts; narrower words are zero-extended.
    localparam int MAX_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Even parity: data bits plus parity bit must hold an even number of ones.
    function automatic logic parity_mismatch(
        input logic [MAX_DATA_W-1:0] data,
        input logic                  parity_bit
    );
        return (^data) ^ parity_bit;
    endfunction

endpackage : uart_rx_pkg

// File: rtl/uart_rx_baud_rate_gen.sv
// Free-running oversampling tick generator; one-cycle tick every
// CLK_FREQ/(BAUD_RATE*N_TICKS) clocks. Shared with the UART transmitter.
module baud_rate_gen #(
    parameter int CLK_FREQ  = 100000000,
    parameter int BAUD_RATE = 9600,
    parameter int N_TICKS   = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * N_TICKS);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    // Next count and tick; tick is registered so it is high exactly while cnt_q == DIV-1.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        tick_d = (cnt_d == CNT_LAST);
    end

    // Divider state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q  <= {CW{1'b0}};
            tick_q <= (CNT_LAST == {CW{1'b0}});
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign o_tick = tick_q;

endmodule : baud_rate_gen

// File: rtl/uart_rx.sv
// UART receiver: synchronises the serial line, samples each bit at its centre
// using an oversampling tick, and presents the frame with a one-cycle done strobe.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int N_DATA       = DEF_N_DATA,
    parameter int PARITY_CHECK = DEF_PARITY_CHECK,
    parameter int N_TICKS      = DEF_N_TICKS,
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD_RATE    = 9600
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_rx,
    output logic [N_DATA+PARITY_CHECK-1:0] o_rx_data,
    output logic                           o_rx_done,
    output logic                           o_parity_err,
    output logic                           o_frame_err
);

    localparam int W  = N_DATA + PARITY_CHECK;
    localparam int TW = $clog2(N_TICKS);
    localparam int BW = (N_DATA > 1) ? $clog2(N_DATA) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(N_TICKS - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(N_TICKS / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N_DATA - 1);

    logic tick_s;

    baud_rate_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD_RATE),
        .N_TICKS  (N_TICKS)
    ) u_baud_rate_gen (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .o_tick(tick_s)
    );

    logic sync1_q;
    logic sync2_q;
    logic rx_s;

    // Two-flop synchroniser for the asynchronous line; resets to the idle level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s = sync2_q;

    rx_state_e          state_q,      state_d;
    logic [TW-1:0]      tick_cnt_q,   tick_cnt_d;
    logic [BW-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [N_DATA-1:0]  shift_q,      shift_d;
    logic               parity_bit_q, parity_bit_d;
    logic [W-1:0]       rx_data_q,    rx_data_d;
    logic               rx_done_q,    rx_done_d;
    logic               parity_err_q, parity_err_d;
    logic               frame_err_q,  frame_err_d;

    // Frame sequencing: next state, counters, shift register and output values.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_bit_d = parity_bit_q;
        rx_data_d    = rx_data_q;
        rx_done_d    = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d    = ST_START;
                    tick_cnt_d = {TW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (tick_s) begin
                    if (tick_cnt_q == TICK_MID) begin
                        // A start bit that is high at its centre was only a glitch.
                        if (!rx_s) begin
                            state_d    = ST_DATA;
                            tick_cnt_d = {TW{1'b0}};
                            bit_cnt_d  = {BW{1'b0}};
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end

            ST_DATA: begin
                if (tick_s) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = {TW{1'b0}};
                        shift_d    = N_DATA'({rx_s, shift_q} >> 1);
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = {BW{1'b0}};
                            state_d   = (PARITY_CHECK != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BW'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end

            ST_PARITY: begin
                if (tick_s) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d   = {TW{1'b0}};
                        parity_bit_d = rx_s;
                        state_d      = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end

            ST_STOP: begin
                if (tick_s) begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d  = {TW{1'b0}};
                        rx_data_d   = W'({parity_bit_q, shift_q});
                        frame_err_d = ~rx_s;
                        if (PARITY_CHECK != 0) begin
                            parity_err_d = parity_mismatch(MAX_DATA_W'(shift_q), parity_bit_q);
                        end else begin
                            parity_err_d = 1'b0;
                        end
                        rx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TW'(1);
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                tick_cnt_d = {TW{1'b0}};
                bit_cnt_d  = {BW{1'b0}};
            end
        endcase
    end

    // Receiver FSM and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= {TW{1'b0}};
            bit_cnt_q    <= {BW{1'b0}};
            shift_q      <= {N_DATA{1'b0}};
            parity_bit_q <= 1'b0;
            rx_data_q    <= {W{1'b0}};
            rx_done_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_bit_q <= parity_bit_d;
            rx_data_q    <= rx_data_d;
            rx_done_q    <= rx_done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign o_rx_data    = rx_data_q;
    assign o_rx_done    = rx_done_q;
    assign o_parity_err = parity_err_q;
    assign o_frame_err  = frame_err_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: drives directed serial frames, queues the
// hand-computed expected words, and a negedge monitor checks each strobe.
module tb_uart_rx;

    localparam int N_DATA       = 8;
    localparam int PARITY_CHECK = 1;
    localparam int N_TICKS      = 16;
    localparam int CLK_FREQ     = 64;
    localparam int BAUD_RATE    = 1;
    localparam int DIV          = CLK_FREQ / (BAUD_RATE * N_TICKS);
    localparam int BIT_CYC      = DIV * N_TICKS;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [8:0] rx_data;
    logic       rx_done;
    logic       parity_err;
    logic       frame_err;

    exp_t exp_q[$];
    int   n_vec      = 0;
    int   n_err      = 0;
    int   strobe_cnt = 0;
    logic done_prev  = 1'b0;

    uart_rx #(
        .N_DATA      (N_DATA),
        .PARITY_CHECK(PARITY_CHECK),
        .N_TICKS     (N_TICKS),
        .CLK_FREQ    (CLK_FREQ),
        .BAUD_RATE   (BAUD_RATE)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rx        (rx),
        .o_rx_data   (rx_data),
        .o_rx_done   (rx_done),
        .o_parity_err(parity_err),
        .o_frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [8:0] d, input logic p, input logic f);
        exp_t e;
        e.data = d;
        e.perr = p;
        e.ferr = f;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe pops one expected frame.
    always @(negedge clk) begin
        if (rx_done === 1'b1) begin
            exp_t e;
            strobe_cnt++;
            check("done_one_cycle", 32'(done_prev), 32'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_strobe: got data %h, expected no strobe", rx_data);
            end else begin
                e = exp_q.pop_front();
                check("rx_data", 32'(rx_data), 32'(e.data));
                check("parity_err", 32'(parity_err), 32'(e.perr));
                check("frame_err", 32'(frame_err), 32'(e.ferr));
            end
        end
        done_prev = rx_done;
    end

    task automatic idle_bits(input int nbits);
        rx = 1'b1;
        repeat (nbits * BIT_CYC) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int ticks);
        rx = v;
        repeat (ticks * DIV) @(negedge clk);
    endtask

    // Full frame: start, LSB-first data, parity, stop held for stop_ticks then high.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_v,
                              input int stop_ticks);
        drive_bit(1'b0, N_TICKS);
        for (int i = 0; i < N_DATA; i++) drive_bit(d[i], N_TICKS);
        drive_bit(par, N_TICKS);
        drive_bit(stop_v, stop_ticks);
        if (stop_ticks < N_TICKS) drive_bit(1'b1, N_TICKS - stop_ticks);
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 4 * BIT_CYC) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_cleared(input string name);
        check({name, "_data"}, 32'(rx_data), 32'd0);
        check({name, "_done"}, 32'(rx_done), 32'd0);
        check({name, "_perr"}, 32'(parity_err), 32'd0);
        check({name, "_ferr"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        int s;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        idle_bits(2);

        push_exp(9'h0A5, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1, N_TICKS);
        drain("frame_a5");

        push_exp(9'h13C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b1, N_TICKS);
        drain("frame_3c");
        check("err_hold_3c", 32'(parity_err), 32'd1);

        push_exp(9'h0FF, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 12);
        idle_bits(2);
        drain("frame_ff_break");
        check("ferr_hold_ff", 32'(frame_err), 32'd1);

        push_exp(9'h101, 1'b0, 1'b0);
        send_frame(8'h01, 1'b1, 1'b1, N_TICKS);
        drain("frame_01");

        s = strobe_cnt;
        drive_bit(1'b0, 3);
        idle_bits(2);
        check("glitch_no_strobe", 32'(strobe_cnt - s), 32'd0);

        push_exp(9'h055, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1, N_TICKS);
        drain("frame_55");

        s = strobe_cnt;
        push_exp(9'h011, 1'b0, 1'b0);
        push_exp(9'h022, 1'b0, 1'b0);
        push_exp(9'h033, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b1, N_TICKS);
        send_frame(8'h22, 1'b0, 1'b1, N_TICKS);
        send_frame(8'h33, 1'b0, 1'b1, N_TICKS);
        drain("b2b_frames");
        check("b2b_strobes", 32'(strobe_cnt - s), 32'd3);

        s = strobe_cnt;
        drive_bit(1'b0, N_TICKS);
        for (int i = 0; i < 4; i++) drive_bit(((8'h7E >> i) & 8'h01) != 8'h00, N_TICKS);
        rx  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check_cleared("midframe_reset");
        @(negedge clk);
        rst = 1'b0;
        idle_bits(12);
        check("partial_no_strobe", 32'(strobe_cnt - s), 32'd0);

        push_exp(9'h081, 1'b0, 1'b0);
        send_frame(8'h81, 1'b0, 1'b1, N_TICKS);
        drain("frame_81");
        idle_bits(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_rx
